// File: rtl/y86_decode.sv
// Y86-64 sequential decode / write-back stage: 15-entry register file with
// combinational operand reads and clocked valE/valM write-back.
module y86_decode (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  icode,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic [3:0]  rsp,
   input  logic [63:0] valE,
   input  logic [63:0] valM,
   output logic [63:0] valA,
   output logic [63:0] valB,
   output logic [63:0] reg_mem0,
   output logic [63:0] reg_mem1,
   output logic [63:0] reg_mem2,
   output logic [63:0] reg_mem3,
   output logic [63:0] reg_mem4,
   output logic [63:0] reg_mem5,
   output logic [63:0] reg_mem6,
   output logic [63:0] reg_mem7,
   output logic [63:0] reg_mem8,
   output logic [63:0] reg_mem9,
   output logic [63:0] reg_mem10,
   output logic [63:0] reg_mem11,
   output logic [63:0] reg_mem12,
   output logic [63:0] reg_mem13,
   output logic [63:0] reg_mem14
);

   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_RRMOVQ = 4'h2,
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_t;

   localparam logic [3:0] RNONE = 4'hF;

   logic [63:0] regs_q [15];
   logic [63:0] regs_d [15];
   logic [3:0]  srcA, srcB, dstE, dstM;

   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      case (icode)
         I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = rA;
         I_RET, I_POPQ:                      srcA = rsp;
         default:                            srcA = RNONE;
      endcase
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = rB;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = rsp;
         default:                            srcB = RNONE;
      endcase
      case (icode)
         I_RRMOVQ, I_IRMOVQ, I_OPQ:          dstE = rB;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     dstE = rsp;
         default:                            dstE = RNONE;
      endcase
      case (icode)
         I_MRMOVQ, I_POPQ:                   dstM = rA;
         default:                            dstM = RNONE;
      endcase
   end

   // Index 0xF matches no entry, so it reads as zero and writes nowhere.
   always_comb begin
      valA = '0;
      valB = '0;
      for (int unsigned i = 0; i < 15; i++) begin
         if (srcA == 4'(i)) valA = regs_q[i];
         if (srcB == 4'(i)) valB = regs_q[i];
      end
   end

   // valM is applied after valE so it wins when both target the same register.
   always_comb begin
      for (int unsigned i = 0; i < 15; i++) begin
         regs_d[i] = regs_q[i];
         if (dstE == 4'(i)) regs_d[i] = valE;
         if (dstM == 4'(i)) regs_d[i] = valM;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 15; i++) begin
         if (reset) regs_q[i] <= '0;
         else       regs_q[i] <= regs_d[i];
      end
   end

   assign reg_mem0  = regs_q[0];
   assign reg_mem1  = regs_q[1];
   assign reg_mem2  = regs_q[2];
   assign reg_mem3  = regs_q[3];
   assign reg_mem4  = regs_q[4];
   assign reg_mem5  = regs_q[5];
   assign reg_mem6  = regs_q[6];
   assign reg_mem7  = regs_q[7];
   assign reg_mem8  = regs_q[8];
   assign reg_mem9  = regs_q[9];
   assign reg_mem10 = regs_q[10];
   assign reg_mem11 = regs_q[11];
   assign reg_mem12 = regs_q[12];
   assign reg_mem13 = regs_q[13];
   assign reg_mem14 = regs_q[14];

endmodule

// File: tb/tb_y86_decode.sv
// Scoreboard bench for y86_decode: a reference register-file model pushes
// expected read values and register contents, popped against the DUT outputs.
module tb_y86_decode;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  icode, rA, rB, rsp;
   logic [63:0] valE, valM;
   logic [63:0] valA, valB;
   logic [63:0] rm [15];

   always #5 clk = ~clk;

   y86_decode dut (
      .clk(clk), .reset(reset), .icode(icode), .rA(rA), .rB(rB), .rsp(rsp),
      .valE(valE), .valM(valM), .valA(valA), .valB(valB),
      .reg_mem0(rm[0]),   .reg_mem1(rm[1]),   .reg_mem2(rm[2]),
      .reg_mem3(rm[3]),   .reg_mem4(rm[4]),   .reg_mem5(rm[5]),
      .reg_mem6(rm[6]),   .reg_mem7(rm[7]),   .reg_mem8(rm[8]),
      .reg_mem9(rm[9]),   .reg_mem10(rm[10]), .reg_mem11(rm[11]),
      .reg_mem12(rm[12]), .reg_mem13(rm[13]), .reg_mem14(rm[14])
   );

   typedef struct {
      string       tag;
      int unsigned idx;   // 0 = valA, 1 = valB, 2+k = reg_mem k
      logic [63:0] exp;
   } exp_t;

   exp_t        sb [$];
   logic [63:0] m [15];
   bit          m_valid = 1'b0;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned step_no = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] observe(input int unsigned idx);
      if (idx == 0) return valA;
      if (idx == 1) return valB;
      return rm[idx-2];
   endfunction

   task automatic push(input string tag, input int unsigned idx, input logic [63:0] exp);
      exp_t e;
      e.tag = tag; e.idx = idx; e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, observe(e.idx), e.exp);
      end
   endtask

   function automatic logic [63:0] mread(input logic [3:0] s);
      return (s == 4'hF) ? 64'd0 : m[s];
   endfunction

   function automatic logic [3:0] f_srcA(input logic [3:0] ic, a, sp);
      case (ic)
         4'h2, 4'h4, 4'h6, 4'hA: return a;
         4'h9, 4'hB:             return sp;
         default:                return 4'hF;
      endcase
   endfunction

   function automatic logic [3:0] f_srcB(input logic [3:0] ic, b, sp);
      case (ic)
         4'h4, 4'h5, 4'h6:       return b;
         4'h8, 4'h9, 4'hA, 4'hB: return sp;
         default:                return 4'hF;
      endcase
   endfunction

   function automatic logic [3:0] f_dstE(input logic [3:0] ic, b, sp);
      case (ic)
         4'h2, 4'h3, 4'h6:       return b;
         4'h8, 4'h9, 4'hA, 4'hB: return sp;
         default:                return 4'hF;
      endcase
   endfunction

   function automatic logic [3:0] f_dstM(input logic [3:0] ic, a);
      return (ic == 4'h5 || ic == 4'hB) ? a : 4'hF;
   endfunction

   task automatic push_reads(input string when);
      push($sformatf("s%0d %s valA", step_no, when), 0, mread(f_srcA(icode, rA, rsp)));
      push($sformatf("s%0d %s valB", step_no, when), 1, mread(f_srcB(icode, rB, rsp)));
   endtask

   task automatic step(input logic [3:0] ic, a, b, sp, input logic [63:0] e, mm, input logic r);
      logic [3:0] de, dm;
      step_no++;
      @(negedge clk);
      icode = ic; rA = a; rB = b; rsp = sp; valE = e; valM = mm; reset = r;
      #1;
      if (m_valid) push_reads("pre");
      drain();
      @(posedge clk);
      #1;
      if (r) begin
         for (int k = 0; k < 15; k++) m[k] = '0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         de = f_dstE(ic, b, sp);
         dm = f_dstM(ic, a);
         if (de != 4'hF) m[de] = e;
         if (dm != 4'hF) m[dm] = mm;
      end
      if (m_valid) begin
         for (int k = 0; k < 15; k++)
            push($sformatf("s%0d reg_mem%0d", step_no, k), 2 + k, m[k]);
         push_reads("post");
      end
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; rsp = 4'h4;
      valE = '0; valM = '0;

      step(4'h1, 4'hF, 4'hF, 4'h4, 64'hAAAA, 64'hBBBB, 1'b1);          // reset
      step(4'h6, 4'h0, 4'h1, 4'h4, 64'h0, 64'h0, 1'b0);                // OPq read of zeros
      step(4'h3, 4'hF, 4'h2, 4'h4, 64'h1234, 64'h0, 1'b0);             // irmovq -> r2
      step(4'h6, 4'h2, 4'h2, 4'h4, 64'h2468, 64'h0, 1'b0);             // OPq reads r2
      step(4'h2, 4'h0, 4'h1, 4'h4, 64'h5, 64'h0, 1'b0);                // rrmovq -> r1
      step(4'h4, 4'h0, 4'h1, 4'h4, 64'hDEAD, 64'hBEEF, 1'b0);          // rmmovq: no write
      step(4'h3, 4'hF, 4'h4, 4'h4, 64'h100, 64'h0, 1'b0);              // rsp = 0x100
      step(4'hB, 4'h3, 4'hF, 4'h4, 64'h108, 64'h77, 1'b0);             // popq %rbx
      step(4'hB, 4'h4, 4'hF, 4'h4, 64'h110, 64'h99, 1'b0);             // popq %rsp: valM wins
      step(4'h3, 4'hF, 4'h5, 4'h4, 64'h7, 64'h0, 1'b0);                // r5 = 7
      step(4'h3, 4'hF, 4'h5, 4'h4, 64'h7, 64'h0, 1'b1);                // reset beats write
      step(4'h1, 4'hF, 4'hF, 4'h4, 64'h55, 64'h66, 1'b0);              // nop
      step(4'h5, 4'hE, 4'hF, 4'h4, 64'h1, 64'hFEED, 1'b0);             // mrmovq -> r14
      step(4'hA, 4'hE, 4'hF, 4'h4, 64'hFFF8, 64'h0, 1'b0);             // pushq
      step(4'h8, 4'hF, 4'hF, 4'h4, 64'hFFF0, 64'h0, 1'b0);             // call
      step(4'h9, 4'hF, 4'hF, 4'h4, 64'hFFF8, 64'h0, 1'b0);             // ret
      step(4'h2, 4'hE, 4'hF, 4'h4, 64'h9, 64'h0, 1'b0);                // dstE = 0xF: ignored

      for (int n = 0; n < 150; n++) begin
         logic [3:0] sp;
         sp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h4;
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              sp, {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 19) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
